// File: rtl/sync_bidir_ramif_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_bidir_ramif_fifo
// Brief    : Single-clock FIFO controller shared by sides A and B over an
//            external dual-port RAM; the writer role is arbitrated and the
//            direction only turns around once the FIFO has drained empty.
// Revision : 1.0 - initial release
// ============================================================================
module sync_bidir_ramif_fifo #(
    parameter int DSIZE         = 8,
    parameter int ASIZE         = 4,
    parameter int AFULL_THRESH  = (1 << ASIZE) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_wreq,
    input  logic             b_wreq,
    output logic             a_wgrant,
    output logic             b_wgrant,
    input  logic             a_winc,
    input  logic [DSIZE-1:0] a_wdata,
    input  logic             a_rinc,
    output logic [DSIZE-1:0] a_rdata,
    output logic             a_rvalid,
    input  logic             b_winc,
    input  logic [DSIZE-1:0] b_wdata,
    input  logic             b_rinc,
    output logic [DSIZE-1:0] b_rdata,
    output logic             b_rvalid,
    output logic             a_full,
    output logic             a_afull,
    output logic             a_empty,
    output logic             a_aempty,
    output logic             b_full,
    output logic             b_afull,
    output logic             b_empty,
    output logic             b_aempty,
    output logic [ASIZE:0]   count,
    output logic [DSIZE-1:0] o_ram_a_wdata,
    input  logic [DSIZE-1:0] i_ram_a_rdata,
    output logic [ASIZE-1:0] o_ram_a_addr,
    output logic             o_ram_a_rinc,
    output logic             o_ram_a_winc,
    output logic [DSIZE-1:0] o_ram_b_wdata,
    input  logic [DSIZE-1:0] i_ram_b_rdata,
    output logic [ASIZE-1:0] o_ram_b_addr,
    output logic             o_ram_b_rinc,
    output logic             o_ram_b_winc
);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_a2b       = 3'd1;
    localparam logic [2:0] c_st_a2b_drain = 3'd2;
    localparam logic [2:0] c_st_b2a       = 3'd3;
    localparam logic [2:0] c_st_b2a_drain = 3'd4;

    localparam logic [ASIZE:0] c_depth     = {1'b1, {ASIZE{1'b0}}};
    localparam logic [ASIZE:0] c_afull_th  = AFULL_THRESH[ASIZE:0];
    localparam logic [ASIZE:0] c_aempty_th = AEMPTY_THRESH[ASIZE:0];

    logic [2:0]     r_state;
    logic [2:0]     w_state_nxt;
    logic [ASIZE:0] r_wptr;
    logic [ASIZE:0] r_rptr;
    logic [ASIZE:0] w_count;
    logic           r_a_rvalid;
    logic           r_b_rvalid;
    logic           w_a_wr, w_b_wr, w_a_rd, w_b_rd;
    logic           w_a_wacc, w_b_wacc, w_a_racc, w_b_racc;
    logic           w_wacc, w_racc;
    logic           w_not_full, w_not_empty;
    logic           w_drain_done;

    assign w_count     = r_wptr - r_rptr;
    assign w_not_full  = (w_count != c_depth);
    assign w_not_empty = (w_count != '0);

    // Writing is only open in the non-drain states; reading continues through drain.
    assign w_a_wr = (r_state == c_st_a2b);
    assign w_b_wr = (r_state == c_st_b2a);
    assign w_a_rd = (r_state == c_st_b2a) || (r_state == c_st_b2a_drain);
    assign w_b_rd = (r_state == c_st_a2b) || (r_state == c_st_a2b_drain);

    assign w_a_wacc = a_winc & w_a_wr & w_not_full;
    assign w_b_wacc = b_winc & w_b_wr & w_not_full;
    assign w_a_racc = a_rinc & w_a_rd & w_not_empty;
    assign w_b_racc = b_rinc & w_b_rd & w_not_empty;
    assign w_wacc   = w_a_wacc | w_b_wacc;
    assign w_racc   = w_a_racc | w_b_racc;

    // No writes happen in drain, so the FIFO empties this cycle iff count == racc.
    assign w_drain_done = (w_count == {{ASIZE{1'b0}}, w_racc});

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (a_wreq)
                    w_state_nxt = c_st_a2b;
                else if (b_wreq)
                    w_state_nxt = c_st_b2a;
            end
            c_st_a2b: begin
                if (!a_wreq)
                    w_state_nxt = (!w_not_empty && !w_wacc) ? c_st_idle : c_st_a2b_drain;
            end
            c_st_a2b_drain: begin
                if (w_drain_done)
                    w_state_nxt = c_st_idle;
            end
            c_st_b2a: begin
                if (!b_wreq)
                    w_state_nxt = (!w_not_empty && !w_wacc) ? c_st_idle : c_st_b2a_drain;
            end
            c_st_b2a_drain: begin
                if (w_drain_done)
                    w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_a_rvalid <= w_a_racc;
            r_b_rvalid <= w_b_racc;
            if (w_wacc)
                r_wptr <= r_wptr + 1'b1;
            if (w_racc)
                r_rptr <= r_rptr + 1'b1;
        end
    end

    assign count    = w_count;
    assign a_wgrant = (r_state == c_st_a2b) || (r_state == c_st_a2b_drain);
    assign b_wgrant = (r_state == c_st_b2a) || (r_state == c_st_b2a_drain);

    assign a_full   = w_a_wr ? !w_not_full : 1'b1;
    assign a_afull  = w_a_wr ? (w_count >= c_afull_th) : 1'b1;
    assign a_empty  = w_a_rd ? !w_not_empty : 1'b1;
    assign a_aempty = w_a_rd ? (w_count <= c_aempty_th) : 1'b1;
    assign b_full   = w_b_wr ? !w_not_full : 1'b1;
    assign b_afull  = w_b_wr ? (w_count >= c_afull_th) : 1'b1;
    assign b_empty  = w_b_rd ? !w_not_empty : 1'b1;
    assign b_aempty = w_b_rd ? (w_count <= c_aempty_th) : 1'b1;

    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;
    assign a_rdata  = i_ram_a_rdata;
    assign b_rdata  = i_ram_b_rdata;

    // Each side owns the RAM port of the same letter; its role picks the pointer.
    assign o_ram_a_addr  = w_a_wr ? r_wptr[ASIZE-1:0] : (w_a_rd ? r_rptr[ASIZE-1:0] : '0);
    assign o_ram_a_winc  = w_a_wacc;
    assign o_ram_a_rinc  = w_a_racc;
    assign o_ram_a_wdata = w_a_wr ? a_wdata : '0;
    assign o_ram_b_addr  = w_b_wr ? r_wptr[ASIZE-1:0] : (w_b_rd ? r_rptr[ASIZE-1:0] : '0);
    assign o_ram_b_winc  = w_b_wacc;
    assign o_ram_b_rinc  = w_b_racc;
    assign o_ram_b_wdata = w_b_wr ? b_wdata : '0;

endmodule
`default_nettype wire
